// File: rtl/debug_op_fetch.sv
// Op-RAM fetch controller: host loads op bytes while idle, start streams a
// terminated op sequence downstream. Optional `DEBUG_OP_FETCH_LOOP_EN` replays the sequence forever.
module debug_op_fetch #(
    parameter logic [7:0]  TERM_BYTE = 8'h00,
    parameter int unsigned MAX_OPS   = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] base_addr,
    input  logic       host_wr,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_data,
    output logic       host_ack,
    output logic [7:0] op_data,
    output logic [7:0] op_addr,
    output logic       op_valid,
    input  logic       op_ready,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic       ram_ce,
    output logic       ram_oce,
    output logic       ram_wre,
    output logic       ram_reset,
    output logic [7:0] ram_ad,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] ptr, ptr_n;
    logic [AW-1:0] base_q, base_n;
    logic [CW-1:0] count, count_n;
    logic [DW-1:0] op_data_n;
    logic [AW-1:0] op_addr_n;
    logic          op_valid_n;
    logic          overrun_n;
    logic          host_ack_n;

    assign busy      = (state != S_IDLE);
    assign ram_oce   = 1'b1;
    assign ram_reset = 1'b0;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            base_q   <= '0;
            count    <= '0;
            op_data  <= '0;
            op_addr  <= '0;
            op_valid <= 1'b0;
            overrun  <= 1'b0;
            host_ack <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            base_q   <= base_n;
            count    <= count_n;
            op_data  <= op_data_n;
            op_addr  <= op_addr_n;
            op_valid <= op_valid_n;
            overrun  <= overrun_n;
            host_ack <= host_ack_n;
        end
    end

    // Next-state, datapath updates and RAM pin drive
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        base_n     = base_q;
        count_n    = count;
        op_data_n  = op_data;
        op_addr_n  = op_addr;
        op_valid_n = op_valid;
        overrun_n  = overrun;
        host_ack_n = 1'b0;
        done       = 1'b0;
        ram_ce     = 1'b0;
        ram_wre    = 1'b0;
        ram_ad     = ptr;
        ram_din    = '0;

        case (state)
            S_IDLE: begin
                if (host_wr) begin
                    ram_ce     = 1'b1;
                    ram_wre    = 1'b1;
                    ram_ad     = host_addr;
                    ram_din    = host_data;
                    host_ack_n = 1'b1;
                end else if (start && !abort) begin
                    ptr_n     = base_addr;
                    base_n    = base_addr;
                    count_n   = '0;
                    overrun_n = 1'b0;
                    state_n   = S_READ;
                end
            end
            S_READ: begin
                ram_ce  = 1'b1;
                state_n = S_CAPT;
            end
            S_CAPT: begin
                if (ram_dout == TERM_BYTE) begin
`ifdef DEBUG_OP_FETCH_LOOP_EN
                    ptr_n   = base_q;
                    count_n = '0;
                    done    = 1'b1;
                    state_n = S_READ;
`else
                    state_n = S_DONE;
`endif
                end else begin
                    op_data_n  = ram_dout;
                    op_addr_n  = ptr;
                    op_valid_n = 1'b1;
                    state_n    = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (op_ready) begin
                    op_valid_n = 1'b0;
                    ptr_n      = AW'(ptr + AW'(1));
                    count_n    = CW'(count + CW'(1));
                    if (CW'(count + CW'(1)) == CW'(MAX_OPS)) begin
                        overrun_n = 1'b1;
                        state_n   = S_DONE;
                    end else begin
                        state_n = S_READ;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Abort beats everything, including a same-cycle handshake
        if (abort && (state != S_IDLE)) begin
            state_n    = S_IDLE;
            ptr_n      = ptr;
            count_n    = count;
            overrun_n  = overrun;
            op_valid_n = 1'b0;
            done       = 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_op_fetch.sv
// Scoreboard bench for debug_op_fetch with a behavioural RAM and a sequence-walking model.
module tb_debug_op_fetch;

    localparam logic [7:0]  TB_TERM    = 8'h00;
    localparam int unsigned TB_MAX_OPS = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, abort, host_wr;
    logic [7:0] base_addr, host_addr, host_data;
    logic       host_ack;
    logic [7:0] op_data, op_addr;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic       busy, done, overrun;
    logic       ram_ce, ram_oce, ram_wre, ram_reset;
    logic [7:0] ram_ad, ram_din, ram_dout;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] a;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         done_cnt = 0;
    bit         rand_rdy = 1'b0;
    bit         fix_rdy = 1'b0;

    debug_op_fetch #(.TERM_BYTE(TB_TERM), .MAX_OPS(TB_MAX_OPS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .host_wr(host_wr), .host_addr(host_addr),
        .host_data(host_data), .host_ack(host_ack), .op_data(op_data),
        .op_addr(op_addr), .op_valid(op_valid), .op_ready(op_ready),
        .busy(busy), .done(done), .overrun(overrun), .ram_ce(ram_ce),
        .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_reset(ram_reset),
        .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, write-through on writes
    always @(posedge clk) begin
        if (ram_ce && ram_oce) begin
            if (ram_wre) begin
                ram[ram_ad] <= ram_din;
                ram_dout    <= ram_din;
            end else begin
                ram_dout <= ram[ram_ad];
            end
        end
    end

    always @(posedge clk) begin
        #2;
        op_ready = rand_rdy ? 1'($urandom_range(0, 1)) : fix_rdy;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (done) done_cnt++;
            if (op_valid && op_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_op: got %h@%h want none", op_data, op_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("op_data", 32'(op_data), 32'(e.d));
                    chk("op_addr", 32'(op_addr), 32'(e.a));
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference: walk memory from base until terminator or the byte budget
    task automatic predict(input logic [7:0] base, output logic ovr);
        logic [7:0] p;
        p   = base;
        ovr = 1'b0;
        for (int n = 0; n < int'(TB_MAX_OPS); n++) begin
            if (ref_mem[p] == TB_TERM) return;
            exp_q.push_back({ref_mem[p], p});
            p = p + 8'd1;
        end
        ovr = 1'b1;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        host_wr = 1'b1; host_addr = a; host_data = d;
        @(posedge clk); #1;
        host_wr = 1'b0;
        ref_mem[a] = d;
        @(negedge clk);
        chk("host_ack", 32'(host_ack), 32'd1);
    endtask

    task automatic pulse_start(input logic [7:0] base);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("overrun_cleared", 32'(overrun), 32'd0);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            chk({nm, "_timeout"}, 32'd1, 32'd0);
            @(posedge clk); #1 abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
        end
    endtask

    task automatic run(input logic [7:0] base, input string nm);
        logic ovr;
        int   d0;
        predict(base, ovr);
        d0 = done_cnt;
        pulse_start(base);
        wait_idle(nm);
        chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_done"}, 32'(done_cnt - d0), 32'd1);
        chk({nm, "_overrun"}, 32'(overrun), 32'(ovr));
        chk({nm, "_valid_low"}, 32'(op_valid), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (!op_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_valid_seen"}, 32'(op_valid), 32'd1);
    endtask

    initial begin
        logic [7:0] seq [8];
        int         d0;
        seq = '{8'h42, 8'h20, 8'h41, 8'h42, 8'h43, 8'h80, 8'h10, 8'h00};
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; host_wr = 1'b0;
        base_addr = '0; host_addr = '0; host_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_op_data", 32'(op_data), 32'd0);
        chk("rst_op_addr", 32'(op_addr), 32'd0);
        chk("rst_ram_ce", 32'(ram_ce), 32'd0);
        chk("rst_ram_wre", 32'(ram_wre), 32'd0);
        chk("rst_ram_ad", 32'(ram_ad), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_ram_pins", 32'({ram_oce, ram_reset}), 32'b10);
        reset_n = 1'b1;

        for (int i = 0; i < 256; i++)
            host_write(8'(i), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        for (int i = 0; i < 8; i++) host_write(8'(i), seq[i]);

`ifdef DEBUG_OP_FETCH_LOOP_EN
        host_write(8'd0, 8'h42); host_write(8'd1, 8'h20); host_write(8'd2, 8'h00);
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back({8'h42, 8'h00});
            exp_q.push_back({8'h20, 8'h01});
        end
        d0 = done_cnt;
        rand_rdy = 1'b1;
        pulse_start(8'h00);
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
        rand_rdy = 1'b0; fix_rdy = 1'b0;
        chk("loop_drained", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        chk("loop_still_busy", 32'(busy), 32'd1);
        chk("loop_done_wraps", (done_cnt - d0 >= 2) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #3 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("loop_abort_idle", 32'(busy), 32'd0);
        exp_q.delete();
`else
        // Plain run with a always-ready sink
        fix_rdy = 1'b1;
        run(8'h00, "basic");

        // Abort in PRESENT together with op_ready; host write while busy is ignored
        fix_rdy = 1'b0;
        d0 = done_cnt;
        pulse_start(8'h00);
        wait_valid("abort");
        host_wr = 1'b1; host_addr = 8'h03; host_data = 8'h77;
        @(negedge clk);
        host_wr = 1'b0;
        @(negedge clk);
        chk("busy_wr_no_ack", 32'(host_ack), 32'd0);
        fix_rdy = 1'b1;
        @(posedge clk); #3 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        fix_rdy = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(op_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // Stall the third byte for five cycles
        begin
            logic ovr;
            int   idx = 0;
            int   k = 0;
            predict(8'h00, ovr);
            d0 = done_cnt;
            pulse_start(8'h00);
            while (busy && k < 500) begin
                @(negedge clk);
                k++;
                if (op_valid && !op_ready) begin
                    if (idx == 2) begin
                        for (int c = 0; c < 5; c++) begin
                            chk("stall_valid", 32'(op_valid), 32'd1);
                            chk("stall_data", 32'(op_data), 32'h41);
                            chk("stall_addr", 32'(op_addr), 32'd2);
                            @(negedge clk);
                        end
                    end
                    fix_rdy = 1'b1;
                    @(negedge clk);
                    fix_rdy = 1'b0;
                    idx++;
                end
            end
            chk("stall_bytes", 32'(idx), 32'd7);
            chk("stall_drained", 32'(exp_q.size()), 32'd0);
            chk("stall_done", 32'(done_cnt - d0), 32'd1);
            exp_q.delete();
        end

        // host_wr and start together: write wins, no run
        d0 = done_cnt;
        @(posedge clk); #1;
        host_wr = 1'b1; host_addr = 8'd200; host_data = 8'h5A; start = 1'b1; base_addr = 8'h00;
        @(posedge clk); #1;
        host_wr = 1'b0; start = 1'b0;
        ref_mem[200] = 8'h5A;
        @(negedge clk);
        chk("wr_start_ack", 32'(host_ack), 32'd1);
        chk("wr_start_idle", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("wr_start_no_done", 32'(done_cnt - d0), 32'd0);

        // Address wrap 255 -> 0
        fix_rdy = 1'b1;
        host_write(8'hFF, 8'hFF); host_write(8'h00, 8'h05); host_write(8'h01, 8'h00);
        run(8'hFF, "wrap");

        // Overrun, then a clean run clears it
        for (int i = 16; i < 32; i++) host_write(8'(i), 8'h11);
        run(8'd16, "ovr");
        run(8'hFF, "ovr_clear");

        // Randomized runs with a random sink
        rand_rdy = 1'b1;
        for (int it = 0; it < 30; it++) begin
            for (int w = 0; w < 3; w++)
                host_write(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            run(8'($urandom), "rand");
        end
        rand_rdy = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/debug_op_fetch.md
Name: debug_op_fetch

Overview:
- Controller that sits directly upstream of the 256x8 debug op RAM.
- Owns the RAM's address, enable and write pins. Loads op bytes from a host port while idle.
- On start, fetches a terminated op sequence byte by byte from a base address and presents each byte downstream on a valid/ready handshake.
- The op RAM is synchronous single-port, bypass read mode: data appears on ram_dout the cycle after an access with ram_ce=1.

Parameters:
TERM_BYTE, 8'h00, op value that ends a sequence; it is never presented downstream
MAX_OPS, 256, maximum bytes fetched per run before overrun (range 1..256)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begin fetch at base_addr (honoured only in IDLE)
abort  in  1  one-cycle pulse, terminate run
base_addr  in  8  first op address, latched on accepted start
host_wr  in  1  write request (honoured only in IDLE)
host_addr  in  8  write address
host_data  in  8  write data
host_ack  out  1  registered one-cycle pulse, the cycle after an accepted write
op_data  out  8  presented op byte
op_addr  out  8  RAM address of op_data
op_valid  out  1  op_data is valid
op_ready  in  1  downstream accepts op_data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, run finished
overrun  out  1  sticky; MAX_OPS reached without TERM_BYTE; cleared on next accepted start
ram_ce  out  1  RAM clock enable
ram_oce  out  1  RAM output enable, constant 1
ram_wre  out  1  RAM write enable
ram_reset  out  1  RAM output reset, constant 0
ram_ad  out  8  RAM address
ram_din  out  8  RAM write data
ram_dout  in  8  RAM read data

Behaviour:
- Reset values:
  - state=IDLE, ptr=0, count=0.
  - op_data=0, op_addr=0, op_valid=0, busy=0, done=0, overrun=0, host_ack=0.
  - ram_ce=ram_wre=0, ram_ad=ram_din=0.
- RAM pins are combinational from state and inputs:
  - IDLE with host_wr: ram_ce=1, ram_wre=1, ram_ad=host_addr, ram_din=host_data.
  - READ: ram_ce=1, ram_wre=0, ram_ad=ptr, ram_din=0.
  - Otherwise: ram_ce=0, ram_wre=0, ram_ad=ptr, ram_din=0.
- States:
  - IDLE:
    - host_wr: write performed, host_ack next cycle; a start in the same cycle is dropped (write wins).
    - start without host_wr: ptr<=base_addr, count<=0, overrun<=0, go to READ.
  - READ: one cycle with the RAM access, then go to CAPT.
  - CAPT:
    - If ram_dout==TERM_BYTE, go to DONE.
    - Otherwise op_data<=ram_dout, op_addr<=ptr, op_valid<=1, go to PRESENT.
  - PRESENT:
    - op_valid held with op_data stable until op_ready=1.
    - On handshake: op_valid<=0, ptr<=ptr+1 (8-bit wrap 8'hFF->8'h00), count<=count+1.
    - Then if count+1==MAX_OPS: overrun<=1, go to DONE. Otherwise go to READ.
  - DONE: done=1 for this single cycle, then go to IDLE.
- Latency:
  - start to first op_valid: 3 cycles (READ, CAPT, valid registered).
  - With op_ready held high, throughput is one byte per 3 cycles.
- abort:
  - Any non-IDLE state goes to IDLE next edge; op_valid<=0; no done pulse; overrun keeps its value.
  - abort has priority over a PRESENT handshake in the same cycle: the byte counts as not consumed.
  - abort in IDLE has no effect; abort and start in the same cycle: abort wins, no run.
- start while busy: ignored. host_wr while busy: ignored, no host_ack, RAM untouched.
- TERM_BYTE at base_addr: the run is READ, CAPT, DONE with no op_valid.
- Asynchronous reset mid-run: immediate return to reset values; a RAM write in flight may or may not complete.

Optional Feature:
- Macro: DEBUG_OP_FETCH_LOOP_EN.
- Defined: TERM_BYTE in CAPT reloads ptr<=latched base_addr and count<=0 and goes to READ instead of DONE. done pulses once per loop-wrap in the CAPT cycle. The run continues until abort or overrun.
- Undefined: behaviour exactly as above; the base-address latch still exists.

Test Plan:
- Host writes 42,20,41,42,43,80,10,00 to addresses 0..7, each write gives host_ack next cycle. Then start with base_addr=0, op_ready=1 -> op_data sequence 42,20,41,42,43,80,10 with op_addr 0..6; done pulses once; busy drops; overrun=0.
- Same contents, op_ready low for 5 cycles on the 3rd byte -> op_valid held, op_data=41 and op_addr=2 stable throughout; no byte lost or duplicated.
- Write FF at address 255, 05 at 0, 00 at 1; start with base_addr=255 -> bytes FF (addr 255), 05 (addr 0), then done (wrap check).
- MAX_OPS=4, RAM filled with 11 and no terminator -> exactly 4 bytes presented, overrun=1, done pulse; next start clears overrun.
- abort asserted in the PRESENT cycle together with op_ready=1 -> IDLE next cycle, op_valid=0, no done pulse. host_wr and start in the same IDLE cycle -> write performed, no run started.
- With DEBUG_OP_FETCH_LOOP_EN defined: contents 42,20,00, base_addr=0 -> repeating 42,20 stream, done pulse per wrap, stops only on abort.
